regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile.sv | 114 +++++++++++
 tb/tb_regfile.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// Register file with per-register pending-write counters and same-cycle write bypass.
// x0 is hard-wired to zero; x1..x31 are stored. Each stored register carries a
// 2-bit count of outstanding reservations, so a read is valid only when every
// pending write is either retired or being written in this very cycle.
module regfile (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  rs1,
    output logic        rs1_valid,
    output logic [31:0] rs1_data,
    input  logic [4:0]  rs2,
    output logic        rs2_valid,
    output logic [31:0] rs2_data,
    input  logic [4:0]  rd,
    input  logic        reserve,
    input  logic [4:0]  wreg0,
    input  logic [31:0] wdata0,
    input  logic        wen0,
    input  logic [4:0]  wreg1,
    input  logic [31:0] wdata1,
    input  logic        wen1
);

    logic [31:0] regs    [1:31];
    logic [1:0]  cnt     [1:31];
    logic [1:0]  cnt_nxt [1:31];

    logic [31:0] rs1_stored, rs2_stored;
    logic [1:0]  rs1_cnt, rs2_cnt;

    // Valid/data for one read port; port 0 wins the bypass as the younger result.
    function automatic logic [32:0] read_port(
        input logic [4:0]  rs,
        input logic [31:0] stored,
        input logic [1:0]  count,
        input logic        w0,
        input logic [4:0]  a0,
        input logic [31:0] d0,
        input logic        w1,
        input logic [4:0]  a1,
        input logic [31:0] d1
    );
        logic        h0, h1, v;
        logic [1:0]  hits;
        logic [31:0] d;
        h0   = w0 && (a0 == rs) && (rs != 5'd0);
        h1   = w1 && (a1 == rs) && (rs != 5'd0);
        hits = {1'b0, h0} + {1'b0, h1};
        v    = (rs == 5'd0) || (count == 2'd0) || ((hits != 2'd0) && (count == hits));
        if (rs == 5'd0)  d = 32'd0;
        else if (h0)     d = d0;
        else if (h1)     d = d1;
        else             d = stored;
        return {v, d};
    endfunction

    // Fetch stored value and pending count for each read index (x0 has neither).
    always_comb begin
        rs1_stored = 32'd0;
        rs1_cnt    = 2'd0;
        rs2_stored = 32'd0;
        rs2_cnt    = 2'd0;
        if (rs1 != 5'd0) begin
            rs1_stored = regs[rs1];
            rs1_cnt    = cnt[rs1];
        end
        if (rs2 != 5'd0) begin
            rs2_stored = regs[rs2];
            rs2_cnt    = cnt[rs2];
        end
    end

    // Combinational read ports, reflecting state before this cycle's reservation.
    always_comb begin
        {rs1_valid, rs1_data} = read_port(rs1, rs1_stored, rs1_cnt,
                                          wen0, wreg0, wdata0, wen1, wreg1, wdata1);
        {rs2_valid, rs2_data} = read_port(rs2, rs2_stored, rs2_cnt,
                                          wen0, wreg0, wdata0, wen1, wreg1, wdata1);
    end

    // Next pending count: retire writes (floor at 0), then add reservation (cap at 3).
    always_comb begin
        logic [1:0] dec;
        logic [1:0] left;
        dec  = 2'd0;
        left = 2'd0;
        for (int r = 1; r < 32; r++) begin
            dec  = {1'b0, wen0 && (wreg0 == 5'(r))} + {1'b0, wen1 && (wreg1 == 5'(r))};
            left = (cnt[r] > dec) ? (cnt[r] - dec) : 2'd0;
            if (reserve && (rd == 5'(r)) && (left != 2'd3)) begin
                left = left + 2'd1;
            end
            cnt_nxt[r] = left;
        end
    end

    // Register and counter state; synchronous reset discards everything in flight.
    always_ff @(posedge clk) begin
        for (int r = 1; r < 32; r++) begin
            if (!reset_n) begin
                regs[r] <= 32'd0;
                cnt[r]  <= 2'd0;
            end else begin
                cnt[r] <= cnt_nxt[r];
                if (wen0 && (wreg0 == 5'(r))) begin
                    regs[r] <= wdata0;
                end else if (wen1 && (wreg1 == 5'(r))) begin
                    regs[r] <= wdata1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: directed vector table followed by a model-driven random phase.
module tb_regfile;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  rs1, rs2, rd, wreg0, wreg1;
    logic        rs1_valid, rs2_valid, reserve, wen0, wen1;
    logic [31:0] rs1_data, rs2_data, wdata0, wdata1;

    regfile dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rs1       (rs1),
        .rs1_valid (rs1_valid),
        .rs1_data  (rs1_data),
        .rs2       (rs2),
        .rs2_valid (rs2_valid),
        .rs2_data  (rs2_data),
        .rd        (rd),
        .reserve   (reserve),
        .wreg0     (wreg0),
        .wdata0    (wdata0),
        .wen0      (wen0),
        .wreg1     (wreg1),
        .wdata1    (wdata1),
        .wen1      (wen1)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [4:0]  rs1, rs2;
        bit          res;
        logic [4:0]  rd;
        bit          w0;
        logic [4:0]  r0;
        logic [31:0] d0;
        bit          w1;
        logic [4:0]  r1;
        logic [31:0] d1;
        bit          chk;
        bit          v1;
        logic [31:0] e1;
        bit          v2;
        logic [31:0] e2;
    } vec_t;

    typedef struct {
        bit          chk;
        int          idx;
        bit          v1;
        logic [31:0] e1;
        bit          v2;
        logic [31:0] e2;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference state for the random phase.
    logic [31:0] m_regs [32];
    int          m_cnt  [32];

    function automatic vec_t mk(bit rst, logic [4:0] a1, logic [4:0] a2, bit res,
                                logic [4:0] d, bit w0, logic [4:0] r0, logic [31:0] d0,
                                bit w1, logic [4:0] r1, logic [31:0] d1, bit chk,
                                bit v1, logic [31:0] e1, bit v2, logic [31:0] e2);
        vec_t v;
        v.rst = rst; v.rs1 = a1; v.rs2 = a2; v.res = res; v.rd = d;
        v.w0 = w0; v.r0 = r0; v.d0 = d0; v.w1 = w1; v.r1 = r1; v.d1 = d1;
        v.chk = chk; v.v1 = v1; v.e1 = e1; v.v2 = v2; v.e2 = e2;
        return v;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, then compare mid-cycle.
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n = !v.rst;
        rs1 = v.rs1; rs2 = v.rs2; reserve = v.res; rd = v.rd;
        wen0 = v.w0; wreg0 = v.r0; wdata0 = v.d0;
        wen1 = v.w1; wreg1 = v.r1; wdata1 = v.d1;
        e.chk = v.chk; e.idx = idx;
        e.v1 = v.v1; e.e1 = v.e1; e.v2 = v.v2; e.e2 = v.e2;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        if (e.chk) begin
            n_vec++;
            if (rs1_valid !== e.v1 || rs1_data !== e.e1 ||
                rs2_valid !== e.v2 || rs2_data !== e.e2) begin
                n_bad++;
                $display("FAIL vec %0d: got v1=%0b d1=%h v2=%0b d2=%h, want v1=%0b d1=%h v2=%0b d2=%h",
                         e.idx, rs1_valid, rs1_data, rs2_valid, rs2_data,
                         e.v1, e.e1, e.v2, e.e2);
            end
        end
    endtask

    // Expected read result from the reference state plus this cycle's writes.
    task automatic model_read(input vec_t v, input logic [4:0] rs,
                              output bit valid, output logic [31:0] data);
        int hits;
        bool_h: begin
            hits = 0;
            if (v.w0 && v.r0 == rs && rs != 0) hits++;
            if (v.w1 && v.r1 == rs && rs != 0) hits++;
        end
        valid = (rs == 0) || (m_cnt[rs] == 0) || (hits >= 1 && m_cnt[rs] == hits);
        if (rs == 0)                   data = 32'd0;
        else if (v.w0 && v.r0 == rs)   data = v.d0;
        else if (v.w1 && v.r1 == rs)   data = v.d1;
        else                           data = m_regs[rs];
    endtask

    // Advance the reference state across the clock edge.
    task automatic model_step(input vec_t v);
        for (int r = 0; r < 32; r++) begin
            if (v.rst || r == 0) begin
                m_regs[r] = 32'd0;
                m_cnt[r]  = 0;
            end else begin
                int dec;
                dec = 0;
                if (v.w0 && v.r0 == 5'(r)) dec++;
                if (v.w1 && v.r1 == 5'(r)) dec++;
                m_cnt[r] = (m_cnt[r] > dec) ? m_cnt[r] - dec : 0;
                if (v.res && v.rd == 5'(r) && m_cnt[r] < 3) m_cnt[r]++;
                if (v.w1 && v.r1 == 5'(r)) m_regs[r] = v.d1;
                if (v.w0 && v.r0 == 5'(r)) m_regs[r] = v.d0;
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; rs1 = '0; rs2 = '0; rd = '0; reserve = 1'b0;
        wen0 = 1'b0; wreg0 = '0; wdata0 = '0; wen1 = 1'b0; wreg1 = '0; wdata1 = '0;

        //                rst rs1 rs2 res rd  w0 r0  d0   w1 r1  d1   chk v1 e1  v2 e2
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 7, 0, 0, 0, 0, 0, 0, 1, 7, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF, 1, 0));
        tbl.push_back(mk(0, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF));
        tbl.push_back(mk(0, 3, 7, 1, 3, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'hDEADBEEF));
        tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 3, 0, 0, 0, 1, 3, 32'h12, 0, 0, 0, 1, 1, 32'h12, 1, 0));
        tbl.push_back(mk(0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h12, 1, 32'h12));
        tbl.push_back(mk(0, 4, 0, 1, 4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 4, 0, 1, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 4, 4, 0, 0, 0, 0, 0, 1, 4, 32'h44, 1, 0, 32'h44, 0, 32'h44));
        tbl.push_back(mk(0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h44, 1, 0));
        tbl.push_back(mk(0, 4, 0, 0, 0, 1, 4, 32'h55, 0, 0, 0, 1, 1, 32'h55, 1, 0));
        tbl.push_back(mk(0, 4, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h55, 1, 32'h55));
        tbl.push_back(mk(0, 9, 9, 0, 0, 1, 9, 32'hA, 1, 9, 32'hB, 1, 1, 32'hA, 1, 32'hA));
        tbl.push_back(mk(0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hA, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 32'hFF, 1, 0, 32'hEE, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'hA));
        // Four reservations on x10: count must stick at 3.
        tbl.push_back(mk(0, 10, 0, 1, 10, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 10, 0, 1, 10, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 10, 0, 1, 10, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 10, 0, 1, 10, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 10, 0, 0, 0, 1, 10, 32'h1, 1, 10, 32'h2, 1, 0, 32'h1, 1, 0));
        tbl.push_back(mk(0, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1, 1, 0));
        tbl.push_back(mk(0, 10, 0, 0, 0, 1, 10, 32'h3, 0, 0, 0, 1, 1, 32'h3, 1, 0));
        tbl.push_back(mk(0, 10, 10, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h3, 1, 32'h3));
        // Write with count 0 must not underflow; then reserve + write together.
        tbl.push_back(mk(0, 11, 0, 0, 0, 0, 0, 0, 1, 11, 32'h77, 1, 1, 32'h77, 1, 0));
        tbl.push_back(mk(0, 11, 0, 1, 11, 0, 0, 0, 0, 0, 0, 1, 1, 32'h77, 1, 0));
        tbl.push_back(mk(0, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h77, 1, 0));
        tbl.push_back(mk(0, 11, 0, 1, 11, 1, 11, 32'h88, 0, 0, 0, 1, 1, 32'h88, 1, 0));
        tbl.push_back(mk(0, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h88, 1, 0));
        tbl.push_back(mk(0, 11, 0, 0, 0, 0, 0, 0, 1, 11, 32'h99, 1, 1, 32'h99, 1, 0));
        tbl.push_back(mk(0, 11, 11, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h99, 1, 32'h99));
        // Mid-operation reset drops pending counts and data, ignores that cycle's writes.
        tbl.push_back(mk(0, 12, 0, 1, 12, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(1, 12, 0, 1, 13, 1, 7, 32'h1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 12, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 13, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Random phase: small index range so bypass hits and counter corners recur.
        for (int i = 0; i < 600; i++) begin
            vec_t v;
            v.rst = (i == 0) || ($urandom_range(0, 59) == 0);
            v.rs1 = 5'($urandom_range(0, 7));
            v.rs2 = 5'($urandom_range(0, 7));
            v.rd  = 5'($urandom_range(0, 7));
            v.res = ($urandom_range(0, 2) == 0) && (v.rst || m_cnt[v.rd] < 3);
            v.w0  = ($urandom_range(0, 2) == 0);
            v.r0  = 5'($urandom_range(0, 7));
            v.d0  = $urandom;
            v.w1  = ($urandom_range(0, 2) == 0);
            v.r1  = 5'($urandom_range(0, 7));
            v.d1  = $urandom;
            v.chk = !v.rst;
            model_read(v, v.rs1, v.v1, v.e1);
            model_read(v, v.rs2, v.v2, v.e2);
            apply(v, 1000 + i);
            model_step(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
